// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiplier sequencer: controller state encoding and client indices.
package mul_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic CLIENT0 = 1'b0;
  localparam logic CLIENT1 = 1'b1;

  function automatic logic [1:0] client_onehot(input logic idx);
    return (idx == CLIENT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the client that did not finish last wins.
module rr_arb2
  import mul_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = client_onehot(CLIENT0);
      2'b10:   win = client_onehot(CLIENT1);
      2'b11:   win = client_onehot(~last);
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_sched.sv
// Sequencer and two-client round-robin arbiter for the repeated-addition multiplier datapath.
// Build option MUL_SCHED_OPSWAP_EN: swap operands at grant so the smaller one drives iterations.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] dp_data,
  output logic             dp_ldA,
  output logic             dp_ldB,
  output logic             dp_ldP,
  output logic             dp_clrP,
  output logic             dp_decB,
  input  logic             dp_eqz,
  input  logic [WIDTH-1:0] dp_prod
);

  state_e           r_state;
  state_e           w_state_d;
  logic             r_owner;
  logic             r_last;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [1:0]       r_gnt;
  logic [1:0]       r_done;
  logic [WIDTH-1:0] r_result;

  logic [1:0]       w_win;
  logic             w_win_idx;
  logic             w_grant;
  logic             w_finish;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH-1:0] w_op_a_d;
  logic [WIDTH-1:0] w_op_b_d;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_win_idx = w_win[1];
  assign w_a_sel   = (w_win_idx == CLIENT1) ? a1 : a0;
  assign w_b_sel   = (w_win_idx == CLIENT1) ? b1 : b0;
  assign w_grant   = (r_state == IDLE) && (req != 2'b00);
  assign w_finish  = (r_state == ACCUM) && dp_eqz;

`ifdef MUL_SCHED_OPSWAP_EN
  // Iteration count follows opB, so put the smaller operand there.
  always_comb begin
    w_op_a_d = w_a_sel;
    w_op_b_d = w_b_sel;
    if (w_b_sel > w_a_sel) begin
      w_op_a_d = w_b_sel;
      w_op_b_d = w_a_sel;
    end
  end
`else
  assign w_op_a_d = w_a_sel;
  assign w_op_b_d = w_b_sel;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_state_d = LOAD_A;
      LOAD_A:  w_state_d = LOAD_B;
      LOAD_B:  w_state_d = ACCUM;
      ACCUM:   if (dp_eqz) w_state_d = DONE;
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_comb begin
    dp_data = '0;
    dp_ldA  = 1'b0;
    dp_ldB  = 1'b0;
    dp_ldP  = 1'b0;
    dp_clrP = 1'b0;
    dp_decB = 1'b0;
    unique case (r_state)
      LOAD_A: begin
        dp_data = r_op_a;
        dp_ldA  = 1'b1;
      end
      LOAD_B: begin
        dp_data = r_op_b;
        dp_ldB  = 1'b1;
        dp_clrP = 1'b1;
      end
      ACCUM: begin
        dp_ldP  = ~dp_eqz;
        dp_decB = ~dp_eqz;
      end
      default: ;
    endcase
  end

  // Job bookkeeping: operands captured at grant, pointer updated only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= CLIENT0;
      r_last   <= CLIENT1;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_gnt    <= 2'b00;
      r_done   <= 2'b00;
      r_result <= '0;
    end else begin
      r_gnt  <= w_grant ? w_win : 2'b00;
      r_done <= w_finish ? client_onehot(r_owner) : 2'b00;
      if (w_grant) begin
        r_owner <= w_win_idx;
        r_op_a  <= w_op_a_d;
        r_op_b  <= w_op_b_d;
      end
      if (w_finish) begin
        r_result <= dp_prod;
        r_last   <= r_owner;
      end
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/mul_sched.md
Name: mul_sched

Overview:
- Sequencing controller and two-requester arbiter for the repeated-addition multiplier datapath (A/B/P registers, B down-counter, B==0 flag).
- Replaces the single-user controller.
  - Accepts multiply requests from two clients and grants them round-robin.
  - Loads the winner's operands into the datapath and drives LdA/LdB/LdP/clrP/decB until eqz.
  - Returns the product to the owning client with a done pulse.

Parameters:
- WIDTH, 16, operand, data-bus and product width; product is taken modulo 2^WIDTH.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  per-client request, level.
- a0  in  WIDTH  client 0 multiplicand.
- b0  in  WIDTH  client 0 multiplier.
- a1  in  WIDTH  client 1 multiplicand.
- b1  in  WIDTH  client 1 multiplier.
- gnt  out  2  one-hot grant pulse, 1 cycle.
- done  out  2  one-hot completion pulse, 1 cycle.
- result  out  WIDTH  product of the last completed job.
- dp_data  out  WIDTH  datapath data_in bus.
- dp_ldA  out  1  datapath load-A strobe.
- dp_ldB  out  1  datapath load-B strobe.
- dp_ldP  out  1  datapath load-P strobe.
- dp_clrP  out  1  datapath clear-P strobe.
- dp_decB  out  1  datapath decrement-B strobe.
- dp_eqz  in  1  datapath flag: B register == 0.
- dp_prod  in  WIDTH  datapath P register.

Behaviour:
- Reset (async, rst_n=0): state IDLE; gnt, done, result and all dp_* outputs 0; op latches 0; rr pointer last=1, so client 0 wins the first tie. Reset mid-job abandons the job with no done; datapath contents become don't-care.
- Datapath strobes are Moore outputs decoded from state; gnt, done and result are registered.
- States:
  - IDLE:
    - If req!=0, arbitrate.
    - Single requester wins outright; if both request, winner = ~last.
    - Latch owner and that client's a/b into internal regs.
    - Assert gnt[owner] for 1 cycle (registered, visible the next cycle) -> LOAD_A.
    - If req==0, stay in IDLE.
  - LOAD_A: dp_data=opA, dp_ldA=1 -> LOAD_B.
  - LOAD_B: dp_data=opB, dp_ldB=1, dp_clrP=1 -> ACCUM.
  - ACCUM:
    - If dp_eqz=1: result<=dp_prod, done[owner]<=1, last<=owner -> DONE.
    - Else: dp_ldP=1, dp_decB=1, stay in ACCUM.
  - DONE: done and new result visible this cycle -> IDLE. done clears the following cycle.
- Latency (IDLE grant cycle = 0):
  - Datapath stays in ACCUM for B+1 cycles (B accumulates plus 1 eqz check).
  - done high in cycle B+4.
  - B=0: done in cycle 4, result 0.
- Handshake:
  - Operands must be valid while req is high.
  - Operands are captured on the grant cycle; a client may change a/b or drop req any time after gnt.
  - A client that keeps req high is eligible again in the IDLE cycle after DONE.
  - No preemption; req changes during a job are ignored.
- Fairness: while both clients request continuously, grants strictly alternate 0,1,0,1...
- Arithmetic: result = (a*b) mod 2^WIDTH as produced by the datapath; the block performs no arithmetic itself, except the optional compare below.
- result holds its value until the next DONE.
- dp_data = 0 outside LOAD_A and LOAD_B.

Optional Feature:
- Macro MUL_SCHED_OPSWAP_EN.
- Defined:
  - At grant, if b > a (unsigned), swap so opA=b and opB=a.
  - Iterations become min(a,b); result is unchanged.
  - Adds one WIDTH-bit comparator on the grant path.
- Undefined: opA=a and opB=b always; iterations = b.

Decomposition:
- Shared package/header mul_sched_pkg holds:
  - State encoding constants: IDLE, LOAD_A, LOAD_B, ACCUM, DONE (3-bit).
  - Client index constants: CLIENT0=0, CLIENT1=1.
- One natural sub-module: rr_arb2.
  - Purely combinational two-way round-robin pick.
  - Inputs: req[1:0], last. Outputs: one-hot win[1:0].
  - Instantiated inside mul_sched; the pointer register stays in mul_sched.
- The bench pairs mul_sched with the existing multiplier datapath model.

Test Plan:
- Reset, then req=01 with a0=17, b0=5 -> gnt=01 in cycle 1; done=01 in cycle 9; result=85; exactly 5 cycles with dp_ldP=1.
- req=10 with a1=9, b1=0 -> done=10 in cycle 4, result=0, dp_ldP never asserted.
- req=11 held high, all operands 3x4 -> grant order 0,1,0,1; each done carries result=12; no back-to-back grants to the same client.
- rst_n pulled low during ACCUM of a 100x50 job -> all outputs 0 immediately with no done; next req=01 with 2x3 -> result=6.
- req0 dropped and a0/b0 changed the cycle after gnt -> result uses the values latched at grant.
- MUL_SCHED_OPSWAP_EN defined, a0=3, b0=200 -> result=600, done at cycle 7. Undefined -> result=600, done at cycle 204.
